alu64_cmd_driver: RTL and testbench
===================================

Name:
alu64_cmd_driver

Overview:
Command-side initiator for the 64-bit registered ALU. It accepts one operation at a time over a valid/ready command port and drives the ALU's A/B/opcode inputs. It waits the ALU's fixed pipeline latency, then captures Z/carry/overflow and returns them over a valid/ready response port. Undefined opcodes are rejected locally and never reach the ALU. The block sits between the instruction/sequencing logic and the ALU instance.

Parameters:
ALU_LATENCY, 2, clock edges from driver operand change to valid ALU result (ALU input register plus output register)
CNT_W, 32, width of statistics counters (used only with ALU_STATS_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  driver can accept a command
cmd_a  input  64  operand A
cmd_b  input  64  operand B
cmd_opcode  input  4  ALU opcode
alu_A  output  64  to ALU A
alu_B  output  64  to ALU B
alu_opcode  output  4  to ALU opcode
alu_Z  input  64  ALU result
alu_carry  input  1  ALU carry
alu_overflow  input  1  ALU overflow
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_z  output  64  captured result
rsp_carry  output  1  captured carry
rsp_overflow  output  1  captured overflow
rsp_err  output  1  1 = opcode rejected, result fields are 0
busy  output  1  FSM not in IDLE
op_count  output  CNT_W  completed legal ops (ALU_STATS_EN only)
ovf_count  output  CNT_W  legal ops returning overflow=1 (ALU_STATS_EN only)

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst: sampled on the rising edge of clk; when rst=0, all state is cleared.
- Reset values: FSM=IDLE, cmd_ready=0 during reset and 1 from the first cycle after release, rsp_valid=0, rsp_z=0, rsp_carry=0, rsp_overflow=0, rsp_err=0, busy=0, alu_A=0, alu_B=0, alu_opcode=4'b0000, latency counter=0, stats counters=0.
- Legal opcodes: 0000, 0001, 0010, 0100, 0101, 1000-1111. Illegal opcodes: 0011, 0110, 0111.
- FSM states:
  - IDLE: cmd_ready=1.
    - On an accept edge (cmd_valid && cmd_ready) with a legal opcode: register cmd_a, cmd_b and cmd_opcode onto alu_A, alu_B and alu_opcode; load the counter with ALU_LATENCY; go to WAIT.
    - On an accept edge with an illegal opcode: leave the alu_* outputs unchanged; set rsp_err=1 and zero the result fields; go to RESP.
  - WAIT: cmd_ready=0; the alu_* outputs stay stable. The counter decrements once per edge. On the edge where the counter equals 1, go to CAPTURE.
  - CAPTURE: for one cycle, sample alu_Z, alu_carry and alu_overflow into the rsp_* registers with rsp_err=0; go to RESP.
  - RESP: rsp_valid=1 and cmd_ready=0. On the edge where rsp_ready=1, clear rsp_valid and return to IDLE.
- Latency, legal op: rsp_valid is asserted ALU_LATENCY+2 cycles after the accept edge (4 cycles at the default).
- Latency, illegal op: rsp_valid is asserted 1 cycle after the accept edge.
- Response fields hold stable while rsp_valid=1 && rsp_ready=0; backpressure is unbounded.
- No command overlap. A new command can be accepted no earlier than the cycle after the response handshake; there is no same-cycle re-accept.
- The driver stores the ALU outputs unmodified and performs no arithmetic of its own.
- cmd_* inputs are ignored whenever cmd_ready=0.
- Reset in any state takes the block to IDLE with the reset values above. An in-flight response is dropped.
- ALU_LATENCY below 1 is unsupported.

Optional Feature:
ALU_STATS_EN
- Defined:
  - op_count increments on the CAPTURE cycle.
  - ovf_count increments on the CAPTURE cycle when alu_overflow=1.
  - Both counters wrap at 2^CNT_W and clear on reset.
- Undefined: op_count and ovf_count are tied to 0; no counter registers exist.

Test Plan:
- ADD (1000), A=5, B=3 -> rsp_z=8, carry=0, overflow=0, err=0; rsp_valid exactly 4 cycles after accept.
- SUB (1001), A=64'h8000_0000_0000_0000, B=1 -> rsp_z=64'h7FFF_FFFF_FFFF_FFFF, overflow=1; ovf_count=1 with ALU_STATS_EN.
- Less-than (1010), A=64'hFFFF_FFFF_FFFF_FFFF, B=1 -> rsp_z=1. Then equal (1110), A=B=64'h1234 -> rsp_z=1.
- Illegal opcode 0110 -> rsp_err=1 and rsp_z=0 one cycle after accept; alu_opcode keeps its previous value; op_count unchanged.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable and cmd_ready=0 throughout. Raise rsp_ready -> rsp_valid=0 next cycle, cmd_ready=1.
- Assert rst=0 for one edge during WAIT -> all outputs at reset values and no response appears. After release, an OR (0001) of 4'hA and 4'h5 -> rsp_z=64'hF.

Source files
------------

// File: rtl/alu64_cmd_driver.sv
// Command-side initiator for the 64-bit registered ALU: accepts one op, waits the ALU pipeline, returns Z/carry/overflow.
// Optional statistics counters are built only when ALU_STATS_EN is defined.
module alu64_cmd_driver #(
  parameter int ALU_LATENCY = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [63:0]      cmd_a,
  input  logic [63:0]      cmd_b,
  input  logic [3:0]       cmd_opcode,
  output logic [63:0]      alu_A,
  output logic [63:0]      alu_B,
  output logic [3:0]       alu_opcode,
  input  logic [63:0]      alu_Z,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_z,
  output logic             rsp_carry,
  output logic             rsp_overflow,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] ovf_count
);

  // state   | meaning
  // IDLE    | ready for a command
  // WAIT    | operands on the ALU, counting down its pipeline latency
  // CAPTURE | ALU result valid, sample it into the response registers
  // RESP    | response presented until the consumer takes it
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_RESP} state_t;

  localparam int LAT_W = $clog2(ALU_LATENCY + 1);

  state_t           state, state_next;
  logic [LAT_W-1:0] lat_cnt;
  logic             accept;
  logic             op_legal;

  assign op_legal  = !(cmd_opcode == 4'b0011 || cmd_opcode == 4'b0110 || cmd_opcode == 4'b0111);
  // Gated by rst so the port reads 0 for the whole reset window.
  assign cmd_ready = (state == S_IDLE) && rst;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (accept) state_next = op_legal ? S_WAIT : S_RESP;
      S_WAIT:    if (lat_cnt == LAT_W'(1)) state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_RESP;
      S_RESP:    if (rsp_ready) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      lat_cnt      <= '0;
      alu_A        <= '0;
      alu_B        <= '0;
      alu_opcode   <= 4'b0000;
      rsp_z        <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op_legal) begin
              alu_A      <= cmd_a;
              alu_B      <= cmd_b;
              alu_opcode <= cmd_opcode;
              lat_cnt    <= LAT_W'(ALU_LATENCY);
            end else begin
              // Rejected ops never touch the ALU; respond with an error and empty result.
              rsp_z        <= '0;
              rsp_carry    <= 1'b0;
              rsp_overflow <= 1'b0;
              rsp_err      <= 1'b1;
            end
          end
        end
        S_WAIT: lat_cnt <= lat_cnt - LAT_W'(1);
        S_CAPTURE: begin
          rsp_z        <= alu_Z;
          rsp_carry    <= alu_carry;
          rsp_overflow <= alu_overflow;
          rsp_err      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_STATS_EN
  logic [CNT_W-1:0] op_cnt_q, ovf_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_cnt_q  <= '0;
      ovf_cnt_q <= '0;
    end else if (state == S_CAPTURE) begin
      op_cnt_q <= op_cnt_q + CNT_W'(1);
      if (alu_overflow) ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
    end
  end

  assign op_count  = op_cnt_q;
  assign ovf_count = ovf_cnt_q;
`else
  assign op_count  = '0;
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_alu64_cmd_driver.sv
// Scoreboard bench for alu64_cmd_driver with a two-stage registered ALU model behind it.
module tb_alu64_cmd_driver;
  localparam int ALU_LATENCY = 2;
  localparam int CNT_W       = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [63:0]      cmd_a, cmd_b;
  logic [3:0]       cmd_opcode;
  logic [63:0]      alu_A, alu_B, alu_Z;
  logic [3:0]       alu_opcode;
  logic             alu_carry, alu_overflow;
  logic             rsp_valid, rsp_ready;
  logic [63:0]      rsp_z;
  logic             rsp_carry, rsp_overflow, rsp_err, busy;
  logic [CNT_W-1:0] op_count, ovf_count;

  alu64_cmd_driver #(.ALU_LATENCY(ALU_LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode),
    .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
    .alu_Z(alu_Z), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  // ALU model: input register then output register.
  logic [63:0] ra, rb, m_z;
  logic [3:0]  rop;
  logic        m_c, m_o;

  always_comb begin
    m_z = '0;
    m_c = 1'b0;
    m_o = 1'b0;
    case (rop)
      4'b0000: m_z = ra & rb;
      4'b0001: m_z = ra | rb;
      4'b0010: m_z = ra ^ rb;
      4'b0100: m_z = ra << rb[5:0];
      4'b0101: m_z = ra >> rb[5:0];
      4'b1000: begin
        {m_c, m_z} = {1'b0, ra} + {1'b0, rb};
        m_o = (ra[63] == rb[63]) && (m_z[63] != ra[63]);
      end
      4'b1001: begin
        m_z = ra - rb;
        m_c = (ra < rb);
        m_o = (ra[63] != rb[63]) && (m_z[63] != ra[63]);
      end
      4'b1010: m_z = {63'd0, $signed(ra) < $signed(rb)};
      4'b1110: m_z = {63'd0, ra == rb};
      default: m_z = '0;
    endcase
  end

  always @(posedge clk) begin
    ra           <= alu_A;
    rb           <= alu_B;
    rop          <= alu_opcode;
    alu_Z        <= m_z;
    alu_carry    <= m_c;
    alu_overflow <= m_o;
  end

  typedef struct {
    logic [63:0] z;
    logic        c;
    logic        o;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          exp_ops = 0;
  int          exp_ovf = 0;
  logic [3:0]  last_op = 4'b0000;
  logic [63:0] last_a = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_stats();
`ifdef ALU_STATS_EN
    chk("op_count", 64'(op_count), 64'(exp_ops));
    chk("ovf_count", 64'(ovf_count), 64'(exp_ovf));
`else
    chk("op_count_tied", 64'(op_count), 64'd0);
    chk("ovf_count_tied", 64'(ovf_count), 64'd0);
`endif
  endtask

  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] ez, input logic ec, input logic eo, input int hold);
    exp_t e;
    int   lat;
    logic legal;
    legal = !(op == 4'b0011 || op == 4'b0110 || op == 4'b0111);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    e.z = legal ? ez : 64'd0;
    e.c = legal & ec;
    e.o = legal & eo;
    e.e = !legal;
    sb.push_back(e);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_opcode = op;
    @(posedge clk); #1;
    if (legal) begin
      last_op = op;
      last_a  = a;
      exp_ops++;
      if (eo) exp_ovf++;
    end
    chk("alu_opcode", 64'(alu_opcode), 64'(last_op));
    chk("alu_A", alu_A, last_a);
    // Keep offering a different command while busy; it must be ignored.
    cmd_a = ~a; cmd_b = ~b; cmd_opcode = 4'b1111;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    cmd_valid = 1'b0;
    chk("latency", 64'(lat), legal ? 64'(ALU_LATENCY + 2) : 64'd1);
    chk("alu_A_stable", alu_A, last_a);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
      e.z = '0; e.c = 1'b0; e.o = 1'b0; e.e = 1'b0;
    end else begin
      e = sb.pop_front();
    end
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("cmd_ready_resp", 64'(cmd_ready), 64'd0);
      chk("rsp_z", rsp_z, e.z);
      chk("rsp_carry", 64'(rsp_carry), 64'(e.c));
      chk("rsp_overflow", 64'(rsp_overflow), 64'(e.o));
      chk("rsp_err", 64'(rsp_err), 64'(e.e));
      if (i < hold) begin
        @(posedge clk); #1;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    chk("cmd_ready_back", 64'(cmd_ready), 64'd1);
    chk_stats();
  endtask

  logic seen;

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_opcode = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu_A", alu_A, 64'd0);
    chk("rst_alu_opcode", 64'(alu_opcode), 64'd0);
    chk("rst_rsp_z", rsp_z, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk_stats();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", 64'(cmd_ready), 64'd1);

    run_op(4'b1000, 64'd5, 64'd3, 64'd8, 1'b0, 1'b0, 0);
    run_op(4'b1001, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 5);
    run_op(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 0);
    run_op(4'b0110, 64'd11, 64'd22, 64'd0, 1'b0, 1'b0, 0);
    run_op(4'b0011, 64'd1, 64'd2, 64'd0, 1'b0, 1'b0, 1);
    run_op(4'b0111, 64'd3, 64'd4, 64'd0, 1'b0, 1'b0, 0);
    run_op(4'b1010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b0, 0);
    run_op(4'b1110, 64'h1234, 64'h1234, 64'd1, 1'b0, 1'b0, 2);

    // Reset while the op is in flight: it must vanish without a response.
    cmd_valid = 1'b1; cmd_a = 64'd7; cmd_b = 64'd9; cmd_opcode = 4'b1000;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("busy_in_wait", 64'(busy), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_ops = 0; exp_ovf = 0; last_op = 4'b0000; last_a = '0;
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_alu_A", alu_A, 64'd0);
    chk("midrst_alu_B", alu_B, 64'd0);
    chk("midrst_alu_opcode", 64'(alu_opcode), 64'd0);
    chk("midrst_rsp_z", rsp_z, 64'd0);
    chk("midrst_rsp_flags", {61'd0, rsp_carry, rsp_overflow, rsp_err}, 64'd0);
    chk_stats();
    rst = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_rst", 64'(seen), 64'd0);

    run_op(4'b0001, 64'hA, 64'h5, 64'hF, 1'b0, 1'b0, 0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
